// File: rtl/cmt_pkg.sv
// +----------------------------------------------------------------------------+
// | cmt_pkg : shared widths, line-count type and packer FSM states             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cmt_pkg;
    localparam int RESULT_WIDTH   = 64;
    localparam int RESULTS_PER_CL = 8;
    localparam int CL_DATA_WIDTH  = RESULT_WIDTH * RESULTS_PER_CL;
    localparam int SIZE_WIDTH     = 43;

    typedef logic [SIZE_WIDTH-1:0] cl_count_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/cmt_line_assembler.sv
// +----------------------------------------------------------------------------+
// | cmt_line_assembler : collects result words into lanes of one cache line    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmt_line_assembler #(
    parameter int                      RESULT_WIDTH   = cmt_pkg::RESULT_WIDTH,
    parameter int                      RESULTS_PER_CL = cmt_pkg::RESULTS_PER_CL,
    parameter logic [RESULT_WIDTH-1:0] PAD_VALUE      = '0,
    parameter int                      CNT_W          = $clog2(RESULTS_PER_CL)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clr,
    input  logic                                   push,
    input  logic                                   flush,
    input  logic [RESULT_WIDTH-1:0]                data,
    output logic [CNT_W-1:0]                       lane_cnt,
    output logic                                   line_full,
    output logic [RESULT_WIDTH*RESULTS_PER_CL-1:0] line
);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RESULTS_PER_CL - 1);

    logic [RESULT_WIDTH-1:0] lanes [RESULTS_PER_CL];

    assign line_full = push && (lane_cnt == LAST_LANE);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane_cnt <= '0;
        end else if (push) begin
            lanes[lane_cnt] <= data;
            lane_cnt        <= line_full ? '0 : lane_cnt + CNT_W'(1);
        end else if (flush) begin
            lane_cnt <= '0;
        end
    end

    // The word being pushed bypasses into its lane so a full line can leave on
    // the same edge; lanes not yet written read as padding for a flush.
    for (genvar k = 0; k < RESULTS_PER_CL; k++) begin : g_lane
        assign line[k*RESULT_WIDTH +: RESULT_WIDTH] =
            (CNT_W'(k) < lane_cnt)           ? lanes[k] :
            (push && CNT_W'(k) == lane_cnt)  ? data     : PAD_VALUE;
    end
endmodule

`default_nettype wire

// File: rtl/cmt_output_packer.sv
// +----------------------------------------------------------------------------+
// | cmt_output_packer : packs FWFT result words into cache lines for DMA write |
// | Optional: CMT_OUTPACK_STALL_CNT_EN adds stall_cycles counter output        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmt_output_packer #(
    parameter int                      RESULT_WIDTH = cmt_pkg::RESULT_WIDTH,
    parameter int                      CL_WIDTH     = cmt_pkg::CL_DATA_WIDTH,
    parameter int                      SIZE_WIDTH   = cmt_pkg::SIZE_WIDTH,
    parameter logic [RESULT_WIDTH-1:0] PAD_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [SIZE_WIDTH-1:0]   wr_size,
    input  logic                    src_empty,
    input  logic [RESULT_WIDTH-1:0] src_data,
    output logic                    src_rd_en,
    input  logic                    src_done,
    input  logic                    dma_full,
    output logic                    dma_wr_en,
    output logic [CL_WIDTH-1:0]     dma_wr_data,
    output logic                    done,
    output logic                    short_err
`ifdef CMT_OUTPACK_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);
    import cmt_pkg::*;

    localparam int               LANES     = CL_WIDTH / RESULT_WIDTH;
    localparam int               LANE_W    = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t                  state, state_nxt;
    logic [SIZE_WIDTH-1:0]   size_r;
    logic [SIZE_WIDTH-1:0]   lines_written;
    logic                    out_vld;
    logic [CL_WIDTH-1:0]     out_data;
    logic [LANE_W-1:0]       lane_cnt;
    logic                    line_full;
    logic [CL_WIDTH-1:0]     line;
    logic [SIZE_WIDTH:0]     lines_committed;
    logic                    run, stop, flush, last_write, short_end, restart;

    always_comb begin
        run             = (state == RUN);
        restart         = go && (state != RUN);
        lines_committed = {1'b0, lines_written} + (SIZE_WIDTH+1)'(out_vld);
        // Only a new line is ever refused; a partly filled line is always finished.
        stop            = (lane_cnt == '0) && (lines_committed >= {1'b0, size_r});
        dma_wr_en       = out_vld && !dma_full;
        src_rd_en       = run && !src_empty && !stop &&
                          !((lane_cnt == LAST_LANE) && out_vld && !dma_wr_en);
        flush           = run && src_done && src_empty && (lane_cnt != '0) && !out_vld;
        last_write      = dma_wr_en && ((lines_written + SIZE_WIDTH'(1)) == size_r);
        short_end       = run && src_done && src_empty && (lane_cnt == '0) &&
                          !out_vld && (lines_written < size_r);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (go) state_nxt = (wr_size == '0) ? DONE : RUN;
            RUN:        if (last_write || short_end) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    cmt_line_assembler #(
        .RESULT_WIDTH   (RESULT_WIDTH),
        .RESULTS_PER_CL (LANES),
        .PAD_VALUE      (PAD_VALUE),
        .CNT_W          (LANE_W)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .clr       (restart),
        .push      (src_rd_en),
        .flush     (flush),
        .data      (src_data),
        .lane_cnt  (lane_cnt),
        .line_full (line_full),
        .line      (line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            size_r        <= '0;
            lines_written <= '0;
            out_vld       <= 1'b0;
            out_data      <= '0;
            done          <= 1'b0;
            short_err     <= 1'b0;
        end else if (restart) begin
            size_r        <= wr_size;
            lines_written <= '0;
            out_vld       <= 1'b0;
            done          <= (wr_size == '0);
            short_err     <= 1'b0;
        end else begin
            if (dma_wr_en) lines_written <= lines_written + SIZE_WIDTH'(1);
            if (line_full || flush) begin
                out_vld  <= 1'b1;
                out_data <= line;
            end else if (dma_wr_en) begin
                out_vld  <= 1'b0;
            end
            if (last_write || short_end) done <= 1'b1;
            if (short_end) short_err <= 1'b1;
        end
    end

    assign dma_wr_data = out_data;

`ifdef CMT_OUTPACK_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart)                            stall_cnt <= '0;
        else if (out_vld && dma_full && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cycles = stall_cnt;
`endif
endmodule

`default_nettype wire

// File: tb/tb_cmt_output_packer.sv
// +----------------------------------------------------------------------------+
// | tb_cmt_output_packer : directed scoreboard bench for cmt_output_packer     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cmt_output_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic [42:0]  wr_size = '0;
    logic         src_done = 1'b0;
    logic         dma_full = 1'b0;
    logic         src_empty;
    logic [63:0]  src_data;
    logic         src_rd_en, dma_wr_en, done, short_err;
    logic [511:0] dma_wr_data;
`ifdef CMT_OUTPACK_STALL_CNT_EN
    logic [31:0]  stall_cycles;
`endif

    always #5 clk = ~clk;

    // FWFT source model
    logic [63:0] mem [0:127];
    logic [7:0]  src_idx = 8'd0;
    logic [7:0]  src_cnt = 8'd0;
    assign src_empty = !(src_idx < src_cnt);
    assign src_data  = mem[src_idx[6:0]];
    always @(posedge clk) if (src_rd_en === 1'b1) src_idx <= src_idx + 8'd1;

    cmt_output_packer dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .wr_size     (wr_size),
        .src_empty   (src_empty),
        .src_data    (src_data),
        .src_rd_en   (src_rd_en),
        .src_done    (src_done),
        .dma_full    (dma_full),
        .dma_wr_en   (dma_wr_en),
        .dma_wr_data (dma_wr_data),
        .done        (done),
        .short_err   (short_err)
`ifdef CMT_OUTPACK_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    int           total = 0;
    int           bad = 0;
    int           writes = 0;
    logic [511:0] exp_q [$];

    function automatic logic [511:0] mk_line(int first, int n);
        logic [511:0] l = '0;
        for (int k = 0; k < 8; k++)
            if (k < n) l[k*64 +: 64] = 64'(first + k);
        return l;
    endfunction

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        logic [511:0] exp;
        @(negedge clk);
        if (dma_wr_en === 1'b1) begin
            writes++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected_write observed=%0h expected=none", dma_wr_data);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                assert (dma_wr_data === exp) else begin
                    bad++;
                    $error("FAIL sb_line observed=%0h expected=%0h", dma_wr_data, exp);
                end
            end
        end
    endtask

    task automatic load(int first, int n);
        for (int i = 0; i < n; i++) begin
            mem[src_cnt[6:0]] = 64'(first + i);
            src_cnt           = src_cnt + 8'd1;
        end
    endtask

    task automatic pulse_go(logic [42:0] s);
        to_drive();
        go      = 1'b1;
        wr_size = s;
        to_sample();
        to_drive();
        go      = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        to_sample();
        while (done !== 1'b1 && n < budget) begin
            to_drive();
            to_sample();
            n++;
        end
        chk("done_timeout", {511'd0, done}, 512'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int           w0, fd, w3, rd_hi, first_rd, last_rd;
        logic [7:0]   base, i0;
        logic [511:0] held;
        logic         hit;

        repeat (3) to_drive();
        rst = 1'b0;
        to_sample();
        chk("reset_done", {511'd0, done}, 512'd0);
        chk("reset_short", {511'd0, short_err}, 512'd0);
        chk("reset_wr_en", {511'd0, dma_wr_en}, 512'd0);
        chk("reset_rd_en", {511'd0, src_rd_en}, 512'd0);
        chk("reset_data", dma_wr_data, 512'd0);

        // zero-size request
        w0 = writes; i0 = src_idx;
        pulse_go(43'd0);
        to_sample();
        chk("size0_done", {511'd0, done}, 512'd1);
        chk("size0_rd_en", {511'd0, src_rd_en}, 512'd0);
        repeat (3) begin to_drive(); to_sample(); end
        chk("size0_writes", 512'(writes - w0), 512'd0);
        chk("size0_pops", 512'(src_idx), 512'(i0));

        // back-to-back full stream
        load(0, 24);
        exp_q.push_back(mk_line(0, 8));
        exp_q.push_back(mk_line(8, 8));
        exp_q.push_back(mk_line(16, 8));
        w0 = writes; fd = 0; w3 = 0; rd_hi = 0; first_rd = 0; last_rd = 0;
        pulse_go(43'd3);
        for (int c = 1; c <= 32; c++) begin
            to_sample();
            if (src_rd_en === 1'b1) begin
                rd_hi++;
                if (first_rd == 0) first_rd = c;
                last_rd = c;
            end
            if (dma_wr_en === 1'b1 && writes == w0 + 3) w3 = c;
            if (done === 1'b1 && fd == 0) fd = c;
            to_drive();
        end
        chk("b2b_rd_count", 512'(rd_hi), 512'd24);
        chk("b2b_rd_contig", 512'(last_rd - first_rd + 1), 512'd24);
        chk("b2b_writes", 512'(writes - w0), 512'd3);
        chk("b2b_done_lat", 512'(fd), 512'(w3 + 1));
        chk("b2b_short", {511'd0, short_err}, 512'd0);

        // backpressure window
        load(0, 24);
        exp_q.push_back(mk_line(0, 8));
        exp_q.push_back(mk_line(8, 8));
        exp_q.push_back(mk_line(16, 8));
        w0 = writes; base = src_idx; held = '0;
        pulse_go(43'd3);
        for (int c = 1; c <= 30; c++) begin
            dma_full = (c >= 9 && c <= 18);
            to_sample();
            if (c == 9) begin
                held = dma_wr_data;
                chk("stall_head", dma_wr_data, mk_line(0, 8));
            end
            if (c >= 9 && c <= 18) chk("stall_wr_en", {511'd0, dma_wr_en}, 512'd0);
            if (c >= 10 && c <= 18) chk("stall_data_hold", dma_wr_data, held);
            if (c == 18) chk("stall_buffered", 512'(src_idx - base), 512'd15);
            to_drive();
        end
        dma_full = 1'b0;
        wait_done(50);
        chk("stall_writes", 512'(writes - w0), 512'd3);
`ifdef CMT_OUTPACK_STALL_CNT_EN
        chk("stall_cycles", 512'(stall_cycles), 512'd10);
`endif

        // partial final line padded
        to_drive();
        load(0, 11);
        src_done = 1'b1;
        exp_q.push_back(mk_line(0, 8));
        exp_q.push_back(mk_line(8, 3));
        w0 = writes;
        pulse_go(43'd2);
        wait_done(60);
        chk("pad_writes", 512'(writes - w0), 512'd2);
        chk("pad_short", {511'd0, short_err}, 512'd0);

        // short stream, then restart
        to_drive();
        load(0, 16);
        exp_q.push_back(mk_line(0, 8));
        exp_q.push_back(mk_line(8, 8));
        w0 = writes;
        pulse_go(43'd4);
        wait_done(60);
        chk("short_writes", 512'(writes - w0), 512'd2);
        chk("short_err", {511'd0, short_err}, 512'd1);
        to_drive();
        src_done = 1'b0;
        load(100, 8);
        exp_q.push_back(mk_line(100, 8));
        w0 = writes;
        pulse_go(43'd1);
        to_sample();
        chk("restart_done_clr", {511'd0, done}, 512'd0);
        chk("restart_short_clr", {511'd0, short_err}, 512'd0);
        to_drive();
        wait_done(40);
        chk("restart_writes", 512'(writes - w0), 512'd1);

        // reset mid-line
        to_drive();
        load(0, 5);
        base = src_idx; w0 = writes; hit = 1'b0;
        pulse_go(43'd1);
        for (int c = 0; c < 40 && !hit; c++) begin
            to_sample();
            if (8'(src_idx - base) == 8'd5) hit = 1'b1;
            else to_drive();
        end
        chk("rst_pre_pops", 512'(src_idx - base), 512'd5);
        to_drive();
        rst = 1'b1;
        to_sample();
        to_drive();
        rst = 1'b0;
        to_sample();
        chk("rst_done", {511'd0, done}, 512'd0);
        chk("rst_short", {511'd0, short_err}, 512'd0);
        chk("rst_wr_en", {511'd0, dma_wr_en}, 512'd0);
        chk("rst_rd_en", {511'd0, src_rd_en}, 512'd0);
        chk("rst_data", dma_wr_data, 512'd0);
        to_drive();
        load(200, 8);
        exp_q.push_back(mk_line(200, 8));
        pulse_go(43'd1);
        wait_done(40);
        chk("rst_new_writes", 512'(writes - w0), 512'd1);
        chk("sb_drained", 512'(exp_q.size()), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
